// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding types and opcode constants for the encoder/loader
// and the field decoder.
package riscv_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } instr_fmt_t;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FULL
   } load_state_t;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: places instruction fields into a 32-bit word for the
// selected format; fmt codes 6 and 7 flag illegal.
module instr_field_packer
   import riscv_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (fmt)
         FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
         FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         FMT_U: word = {imm[31:12], rd, opcode};
         FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts instruction field tuples, encodes them and writes the words to
// consecutive imem addresses through a one-deep registered write port.
module instr_encoder_loader
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [6:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              full,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   load_state_t       state, state_next;
   logic [ADDR_W-1:0] acc_ptr;
   logic [31:0]       word;
   logic              illegal;
   logic              accept;
   logic              load_word;
   logic              done;

   instr_field_packer u_packer (
      .fmt     (fmt),
      .opcode  (opcode),
      .rd      (rd),
      .rs1     (rs1),
      .rs2     (rs2),
      .funct3  (funct3),
      .funct7  (funct7),
      .imm     (imm),
      .word    (word),
      .illegal (illegal)
   );

   assign in_ready  = (state == ST_LOAD) && !start && (!mem_we || mem_ready);
   assign accept    = in_valid && in_ready;
   assign load_word = accept && !illegal;
   assign done      = mem_we && mem_ready;
   assign full      = (state == ST_FULL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (start)
         state_next = ST_LOAD;
      else if (load_word && (acc_ptr == '1))
         state_next = ST_FULL;
   end

   // A write still pending at start completes at its old address and is
   // counted toward the new run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_ptr   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
         count     <= '0;
      end else begin
         if (start)          count <= (ADDR_W+1)'(done);
         else if (done)      count <= count + (ADDR_W+1)'(1);

         if (start)                  err <= 1'b0;
         else if (accept && illegal) err <= 1'b1;

         if (start)          acc_ptr <= base_addr;
         else if (load_word) acc_ptr <= acc_ptr + ADDR_W'(1);

         if (load_word) begin
            mem_we    <= 1'b1;
            mem_addr  <= acc_ptr;
            mem_wdata <= word;
         end else if (mem_ready) begin
            mem_we <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed scenarios plus a
// randomized run against a transaction-level model of the loader.
module tb_instr_encoder_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int OW     = 2*ADDR_W + 36;
   typedef logic [OW-1:0] obs_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        fmt = '0;
   logic [6:0]        opcode = '0;
   logic [4:0]        rd = '0;
   logic [4:0]        rs1 = '0;
   logic [4:0]        rs2 = '0;
   logic [2:0]        funct3 = '0;
   logic [6:0]        funct7 = '0;
   logic [31:0]       imm = '0;
   logic              mem_we;
   logic              mem_ready = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              full;
   logic              err;
   logic [ADDR_W:0]   count;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   bit                m_loading, m_pending, m_err, m_full;
   int unsigned       m_ptr, m_count;
   logic [ADDR_W-1:0] m_addr;
   logic [31:0]       m_data;

   obs_t dut_obs;
   assign dut_obs = {mem_we, mem_addr, mem_wdata, count, err, full};

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fmt       (fmt),
      .opcode    (opcode),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .funct3    (funct3),
      .funct7    (funct7),
      .imm       (imm),
      .mem_we    (mem_we),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .full      (full),
      .err       (err),
      .count     (count)
   );

   // Encoding from the field-placement table, using shifts and masks.
   function automatic logic [31:0] model_enc();
      bit [31:0] op = 32'(opcode), d = 32'(rd), s1 = 32'(rs1), s2 = 32'(rs2);
      bit [31:0] f3 = 32'(funct3), f7 = 32'(funct7), im = imm;
      bit [31:0] common = op + (f3 << 12) + (s1 << 15);
      case (fmt)
         3'd0: return common + (d << 7) + (s2 << 20) + (f7 << 25);
         3'd1: return common + (d << 7) + ((im & 32'hFFF) << 20);
         3'd2: return common + ((im & 31) << 7) + (s2 << 20) + (((im >> 5) & 127) << 25);
         3'd3: return common + (((im >> 11) & 1) << 7) + (((im >> 1) & 15) << 8)
                      + (s2 << 20) + (((im >> 5) & 63) << 25) + (((im >> 12) & 1) << 31);
         3'd4: return op + (d << 7) + (im & 32'hFFFFF000);
         default: return op + (d << 7) + (im & 32'h000FF000) + (((im >> 11) & 1) << 20)
                      + (((im >> 1) & 1023) << 21) + (((im >> 20) & 1) << 31);
      endcase
   endfunction

   function automatic bit model_ready();
      return m_loading && !start && (!m_pending || mem_ready);
   endfunction

   function automatic obs_t model_obs();
      return {m_pending, m_addr, m_data, (ADDR_W+1)'(m_count), m_err, m_full};
   endfunction

   task automatic model_reset();
      m_loading = 0; m_pending = 0; m_err = 0; m_full = 0;
      m_ptr = 0; m_count = 0; m_addr = '0; m_data = '0;
   endtask

   // Advance one clock edge and apply the loader rules to the model.
   task automatic tick();
      bit rdy, done;
      rdy = model_ready();
      @(posedge clk);
      done = m_pending && mem_ready;
      if (done) m_pending = 0;
      if (start) begin
         m_loading = 1; m_ptr = 32'(base_addr); m_count = 32'(done);
         m_err = 0; m_full = 0;
      end else begin
         if (done) m_count++;
         if (in_valid && rdy) begin
            if (fmt > 3'd5) m_err = 1;
            else begin
               m_pending = 1;
               m_addr = ADDR_W'(m_ptr);
               m_data = model_enc();
               if (m_ptr == DEPTH - 1) begin
                  m_full = 1; m_loading = 0;
               end
               m_ptr = (m_ptr + 1) % DEPTH;
            end
         end
      end
      #1;
   endtask

   task automatic set_tuple(input logic [2:0] f, input logic [6:0] op,
                            input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
      fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
      funct3 = f3; funct7 = f7; imm = im;
   endtask

   task automatic rand_tuple(input bit allow_illegal);
      logic [2:0] f;
      f = 3'($urandom_range(0, 5));
      if (allow_illegal && ($urandom_range(0, 15) == 0)) f = 3'($urandom_range(6, 7));
      set_tuple(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                3'($urandom), 7'($urandom), $urandom);
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] base);
      start = 1; base_addr = base; in_valid = 0; #1;
      tick();
      start = 0;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 0;
      in_valid = 1; mem_ready = 1; #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++; $display("FAIL reset_in_ready got %b expected 0", in_ready);
      end
      vectors++;
      if (dut_obs !== obs_t'(0)) begin
         miscompares++; $display("FAIL reset_outs got %h expected 0", dut_obs);
      end
      tick();
      in_valid = 0;
      vectors++;
      if (dut_obs !== model_obs()) begin
         miscompares++; $display("FAIL idle_no_accept got %h expected %h", dut_obs, model_obs());
      end
   endtask

   task automatic test_r_basic();
      mem_ready = 1;
      do_start('0);
      set_tuple(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, $urandom);
      in_valid = 1; #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL r_in_ready got %b expected 1", in_ready);
      end
      tick();
      in_valid = 0;
      vectors++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h00, 32'h002081B3}) begin
         miscompares++;
         $display("FAIL r_write got we=%b addr=%h data=%h expected we=1 addr=00 data=002081b3",
                  mem_we, mem_addr, mem_wdata);
      end
      tick();
      vectors++;
      if (count !== 9'd1 || dut_obs !== model_obs()) begin
         miscompares++; $display("FAIL r_count got %h expected %h", dut_obs, model_obs());
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  f  [3] = '{3'd1, 3'd2, 3'd5};
      logic [6:0]  op [3] = '{7'h13, 7'h23, 7'h6F};
      logic [4:0]  d  [3] = '{5'd5, 5'($urandom), 5'd1};
      logic [4:0]  s1 [3] = '{5'd0, 5'd1, 5'($urandom)};
      logic [4:0]  s2 [3] = '{5'($urandom), 5'd2, 5'($urandom)};
      logic [2:0]  f3 [3] = '{3'd0, 3'd2, 3'($urandom)};
      logic [31:0] im [3] = '{32'hFFFFFFFF, 32'd8, 32'd8 | 32'($urandom_range(0, 1))};
      logic [31:0] ex [3] = '{32'hFFF00293, 32'h0020A423, 32'h008000EF};
      mem_ready = 1;
      for (int unsigned i = 0; i < 3; i++) begin
         set_tuple(f[i], op[i], d[i], s1[i], s2[i], f3[i], 7'($urandom), im[i]);
         in_valid = 1; #1;
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_in_ready[%0d] got %b expected 1", i, in_ready);
         end
         tick();
         vectors++;
         if (mem_wdata !== ex[i] || mem_addr !== ADDR_W'(i + 1) || dut_obs !== model_obs()) begin
            miscompares++;
            $display("FAIL b2b_word[%0d] got addr=%h data=%h expected addr=%h data=%h",
                     i, mem_addr, mem_wdata, ADDR_W'(i + 1), ex[i]);
         end
      end
      in_valid = 0; #1;
      tick();
      vectors++;
      if (count !== 9'd4 || dut_obs !== model_obs()) begin
         miscompares++; $display("FAIL b2b_count got %h expected %h", dut_obs, model_obs());
      end
   endtask

   task automatic test_backpressure();
      mem_ready = 1;
      set_tuple(3'd4, 7'h37, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                7'($urandom), $urandom);
      in_valid = 1; #1;
      tick();
      set_tuple(3'd3, 7'h63, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                7'($urandom), $urandom);
      for (int unsigned i = 0; i < 3; i++) begin
         mem_ready = 0; #1;
         vectors++;
         if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_in_ready[%0d] got %b expected 0", i, in_ready);
         end
         tick();
         vectors++;
         if (dut_obs !== model_obs()) begin
            miscompares++; $display("FAIL bp_hold[%0d] got %h expected %h", i, dut_obs, model_obs());
         end
      end
      mem_ready = 1; #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL bp_release_ready got %b expected 1", in_ready);
      end
      tick();
      in_valid = 0;
      vectors++;
      if (dut_obs !== model_obs()) begin
         miscompares++; $display("FAIL bp_release got %h expected %h", dut_obs, model_obs());
      end
      tick();
   endtask

   task automatic test_full();
      mem_ready = 1;
      do_start(ADDR_W'(DEPTH - 2));
      for (int unsigned i = 0; i < 2; i++) begin
         rand_tuple(0);
         in_valid = 1; #1;
         tick();
      end
      vectors++;
      if (full !== 1'b1 || in_ready !== 1'b0 || dut_obs !== model_obs()) begin
         miscompares++;
         $display("FAIL full_set got full=%b in_ready=%b obs=%h expected full=1 in_ready=0 obs=%h",
                  full, in_ready, dut_obs, model_obs());
      end
      rand_tuple(0);
      in_valid = 1; #1;
      tick();
      in_valid = 0;
      vectors++;
      if (count !== 9'd2 || mem_we !== 1'b0 || dut_obs !== model_obs()) begin
         miscompares++; $display("FAIL full_drain got %h expected %h", dut_obs, model_obs());
      end
      do_start('0);
      vectors++;
      if (full !== 1'b0 || dut_obs !== model_obs()) begin
         miscompares++; $display("FAIL full_clear got %h expected %h", dut_obs, model_obs());
      end
   endtask

   task automatic test_illegal();
      mem_ready = 1;
      do_start(ADDR_W'(10));
      rand_tuple(0);
      fmt = 3'd7;
      in_valid = 1; #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL illegal_in_ready got %b expected 1", in_ready);
      end
      tick();
      in_valid = 0;
      vectors++;
      if (err !== 1'b1 || mem_we !== 1'b0 || count !== 9'd0 || dut_obs !== model_obs()) begin
         miscompares++; $display("FAIL illegal_err got %h expected %h", dut_obs, model_obs());
      end
      do_start(ADDR_W'(10));
      vectors++;
      if (err !== 1'b0 || dut_obs !== model_obs()) begin
         miscompares++; $display("FAIL illegal_clear got %h expected %h", dut_obs, model_obs());
      end
   endtask

   task automatic test_start_pending();
      mem_ready = 1;
      do_start(ADDR_W'(20));
      rand_tuple(0);
      in_valid = 1; mem_ready = 0; #1;
      tick();
      in_valid = 0;
      do_start(ADDR_W'(100));
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(20) || count !== 9'd0) begin
         miscompares++;
         $display("FAIL sp_pending got we=%b addr=%h count=%0d expected we=1 addr=14 count=0",
                  mem_we, mem_addr, count);
      end
      mem_ready = 1; #1;
      tick();
      vectors++;
      if (count !== 9'd1 || dut_obs !== model_obs()) begin
         miscompares++; $display("FAIL sp_counted got %h expected %h", dut_obs, model_obs());
      end
      rand_tuple(0);
      in_valid = 1; #1;
      tick();
      in_valid = 0;
      vectors++;
      if (mem_addr !== ADDR_W'(100) || dut_obs !== model_obs()) begin
         miscompares++; $display("FAIL sp_new_base got %h expected %h", dut_obs, model_obs());
      end
   endtask

   task automatic test_random();
      for (int unsigned i = 0; i < 400; i++) begin
         start = (i == 0) || ($urandom_range(0, 39) == 0);
         base_addr = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(DEPTH - 6, DEPTH - 1))
                                                 : ADDR_W'($urandom);
         in_valid = ($urandom_range(0, 9) < 7);
         mem_ready = ($urandom_range(0, 9) < 6);
         rand_tuple(1);
         #1;
         vectors++;
         if (in_ready !== model_ready()) begin
            miscompares++;
            $display("FAIL rand_in_ready[%0d] got %b expected %b", i, in_ready, model_ready());
         end
         tick();
         vectors++;
         if (dut_obs !== model_obs()) begin
            miscompares++; $display("FAIL rand_outs[%0d] got %h expected %h", i, dut_obs, model_obs());
         end
      end
      start = 0; in_valid = 0;
   endtask

   task automatic test_reset_mid();
      mem_ready = 1;
      do_start(ADDR_W'(5));
      rand_tuple(0);
      in_valid = 1; mem_ready = 0; #1;
      tick();
      in_valid = 0; #2;
      reset = 1; #1;
      model_reset();
      vectors++;
      if (dut_obs !== obs_t'(0) || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid got obs=%h in_ready=%b expected 0 and 0", dut_obs, in_ready);
      end
      @(posedge clk);
      #1 reset = 0;
      rand_tuple(0);
      in_valid = 1; mem_ready = 1; #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++; $display("FAIL reset_mid_idle got in_ready=%b expected 0", in_ready);
      end
      tick();
      in_valid = 0;
      vectors++;
      if (dut_obs !== obs_t'(0)) begin
         miscompares++; $display("FAIL reset_mid_after got %h expected 0", dut_obs);
      end
   endtask

   initial begin
      test_reset();
      test_r_basic();
      test_back_to_back();
      test_backpressure();
      test_full();
      test_illegal();
      test_start_pending();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Packs RISC-V instruction fields (opcode, rd, rs1, rs2, funct3, funct7, immediate) into 32-bit words, the inverse of the instruction field decoder. Writes the words sequentially into instruction memory through a write port with backpressure. Used by the test/boot path to place a program in imem before the core fetches and decodes it. Input is a valid/ready stream; output is a one-deep registered write stage.

## Interface
- ADDR_W, 8, imem word-address width; the memory holds 2**ADDR_W words.

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse: load base_addr, clear count/err/full, enter LOAD
- base_addr  in  ADDR_W  first write address, sampled on start
- in_valid  in  1  field tuple valid
- in_ready  out  1  tuple accepted when in_valid && in_ready
- fmt  in  3  instr_fmt_t: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 are illegal
- opcode  in  7
- rd  in  5
- rs1  in  5
- rs2  in  5
- funct3  in  3
- funct7  in  7
- imm  in  32  immediate, already sign-extended
- mem_we  out  1  write request
- mem_ready  in  1  write completes when mem_we && mem_ready
- mem_addr  out  ADDR_W
- mem_wdata  out  32
- full  out  1  last memory word accepted; no further input accepted
- err  out  1  sticky; set when an illegal fmt is accepted
- count  out  ADDR_W+1  number of completed writes since start

## Operation
- **States:** IDLE, LOAD, FULL. Reset enters IDLE.
  - start in any state → LOAD, with acc_ptr=base_addr, count=0, err=0, full=0.
- **Accept:** in_ready = (state==LOAD) && !start && (!mem_we || mem_ready).
- **On accept with a legal fmt:**
  - The encoded word and acc_ptr load into the output register; mem_we is set.
  - acc_ptr increments.
  - If acc_ptr was all-ones: go to FULL and set full. There is no wrap-around.
- **On accept with an illegal fmt:** the tuple is consumed, nothing is written, err is set, and acc_ptr and count do not change.
- **Output register:** mem_we clears when mem_ready is high and no new word is loaded in the same cycle. count increments on every completed write.
- **start while a write is pending:** the pending write finishes at its old address and is counted in the new count. The new base applies only to later accepts.
- **Encoding.** Unused fields are ignored; imm[0] is ignored for B and J.
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode

## Timing
- **Reset values:** in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, full=0, err=0, count=0, acc_ptr=0.
- **Reset during operation:** any pending write is dropped immediately.
- **Latency:** a tuple accepted in cycle N drives mem_we/mem_addr/mem_wdata from cycle N+1. These are held stable until the cycle where mem_ready is sampled high.
- **Throughput:** one word per cycle while mem_ready stays high.
- **Backpressure:** when mem_we && !mem_ready, in_ready is low.
- **start and in_valid in the same cycle:** start wins; the tuple is not accepted.
- **full:** rises in the cycle after the last address is accepted. in_ready is low from that cycle on. The final write still drains.

## Structure
- **Package `riscv_pkg`:** holds instr_fmt_t and the opcode constants OP_R=7'h33, OP_IMM=7'h13, OP_STORE=7'h23, OP_BRANCH=7'h63, OP_LUI=7'h37, OP_JAL=7'h6F. The decoder shares these.
- **Sub-module `instr_field_packer`:** purely combinational; takes fmt and the fields, outputs word and illegal. The FSM, pointer and output register live in the top.

## Test plan
- Reset, start with base_addr=0, then R: opcode 0x33, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 → one cycle later mem_we=1, mem_addr=0, mem_wdata=0x002081B3; count=1.
- I, U, S and J checks with mem_ready held high, issued back-to-back, expect 1/cycle:
  - I: addi x5,x0 with imm=0xFFFFFFFF → 0xFFF00293
  - S: funct3=2, rs1=1, rs2=2, imm=8 → 0x0020A423
  - J: rd=1, imm=8 → 0x008000EF
- Backpressure: mem_ready low for 3 cycles with a word pending → mem_addr and mem_wdata held, in_ready=0, count unchanged; completes on the 4th cycle.
- ADDR_W=2, base_addr=2: two accepts → full=1 and in_ready=0 after the second; a third in_valid is not accepted; count reaches 2; a new start with base 0 clears full.
- fmt=7 → tuple accepted, err=1, no mem_we, count unchanged; a following start clears err.
- Reset asserted while mem_we=1 and mem_ready=0 → all outputs are 0 immediately and the state is IDLE.
